// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle arithmetic/logic ops, one-bit-per-cycle
// shifts, with abort (flush) and a registered result/zero flag.
module alu_multicycle #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [3:0]      ALUCtrl_i,
    input  logic [XLEN-1:0] OperandA_i,
    input  logic [XLEN-1:0] OperandB_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] Result_o,
    output logic            Zero_o
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_SLL = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0111;
    localparam logic [3:0] OP_PSB = 4'b1000;

    state_e          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic [XLEN-1:0] work_q, work_d;
    logic [3:0]      op_q, op_d;
    logic [4:0]      cnt_q, cnt_d;

    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] shifted;
    logic [4:0]      shamt;
    logic            is_shift;

    assign shamt = OperandB_i[4:0];

    assign is_shift = (ALUCtrl_i == OP_SLL) ||
                      (ALUCtrl_i == OP_SRL) ||
                      (ALUCtrl_i == OP_SRA);

    // Shift codes only reach this path with a zero shift amount.
    always_comb begin
        alu_res = '0;
        case (ALUCtrl_i)
            OP_ADD:  alu_res = OperandA_i + OperandB_i;
            OP_SUB:  alu_res = OperandA_i - OperandB_i;
            OP_SLL:  alu_res = OperandA_i;
            OP_XOR:  alu_res = OperandA_i ^ OperandB_i;
            OP_SRL:  alu_res = OperandA_i;
            OP_SRA:  alu_res = OperandA_i;
            OP_OR:   alu_res = OperandA_i | OperandB_i;
            OP_AND:  alu_res = OperandA_i & OperandB_i;
            OP_PSB:  alu_res = OperandB_i;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        shifted = work_q;
        case (op_q)
            OP_SLL:  shifted = work_q << 1;
            OP_SRL:  shifted = work_q >> 1;
            default: shifted = {work_q[XLEN-1], work_q[XLEN-1:1]};
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        work_d   = work_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    state_d = IDLE;
                    if (start_i) begin
                        if (is_shift && (shamt != 5'd0)) begin
                            work_d  = OperandA_i;
                            op_d    = ALUCtrl_i;
                            cnt_d   = shamt;
                            state_d = SHIFT;
                        end else begin
                            result_d = alu_res;
                            zero_d   = (alu_res == '0);
                            state_d  = DONE;
                        end
                    end
                end
                SHIFT: begin
                    work_d = shifted;
                    cnt_d  = cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        result_d = shifted;
                        zero_d   = (shifted == '0);
                        state_d  = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
            work_q   <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            work_q   <= work_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy_o   = (state_q == SHIFT);
    assign done_o   = (state_q == DONE);
    assign Result_o = result_q;
    assign Zero_o   = zero_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed-vector bench for alu_multicycle.
module tb_alu_multicycle;

    logic        clk;
    logic        rst;
    logic        start;
    logic        flush;
    logic [3:0]  ctrl;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        busy;
    logic        done;
    logic [31:0] res;
    logic        zero;

    int checks = 0;
    int errors = 0;

    alu_multicycle #(.XLEN(32)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .flush_i    (flush),
        .ALUCtrl_i  (ctrl),
        .OperandA_i (opa),
        .OperandB_i (opb),
        .busy_o     (busy),
        .done_o     (done),
        .Result_o   (res),
        .Zero_o     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single accept edge; returns in the cycle after it.
    task automatic issue(input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b);
        ctrl  = c;
        opa   = a;
        opb   = b;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (res !== 32'h0 || zero !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: res=%h zero=%b done=%b busy=%b want 0/1/0/0",
                     res, zero, done, busy);
        end
    endtask

    task automatic test_add();
        issue(4'b0000, 32'd5, 32'd7);
        checks++;
        if (done !== 1'b1 || res !== 32'd12 || zero !== 1'b0) begin
            errors++;
            $display("FAIL add: done=%b res=%h zero=%b want 1/0000000c/0",
                     done, res, zero);
        end
        step();
        checks++;
        if (done !== 1'b0 || res !== 32'd12) begin
            errors++;
            $display("FAIL add_hold: done=%b res=%h want 0/0000000c", done, res);
        end
    endtask

    task automatic test_sub();
        issue(4'b0001, 32'd3, 32'd5);
        checks++;
        if (done !== 1'b1 || res !== 32'hFFFF_FFFE || zero !== 1'b0) begin
            errors++;
            $display("FAIL sub_neg: done=%b res=%h zero=%b want 1/fffffffe/0",
                     done, res, zero);
        end
        issue(4'b0001, 32'd9, 32'd9);
        checks++;
        if (done !== 1'b1 || res !== 32'h0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL sub_zero: done=%b res=%h zero=%b want 1/0/1",
                     done, res, zero);
        end
        step();
    endtask

    task automatic test_logic();
        logic [3:0]  tc[7];
        logic [31:0] ta[7];
        logic [31:0] tb[7];
        logic [31:0] te[7];
        tc[0] = 4'b0011; ta[0] = 32'hF0F0_0000; tb[0] = 32'h0FF0_00FF;
        te[0] = 32'hFF00_00FF;
        tc[1] = 4'b0110; ta[1] = 32'h1200_0000; tb[1] = 32'h0000_0034;
        te[1] = 32'h1200_0034;
        tc[2] = 4'b0111; ta[2] = 32'hFF00_FF00; tb[2] = 32'h0F0F_0F0F;
        te[2] = 32'h0F00_0F00;
        tc[3] = 4'b1000; ta[3] = 32'd123;       tb[3] = 32'hDEAD_BEEF;
        te[3] = 32'hDEAD_BEEF;
        tc[4] = 4'b1001; ta[4] = 32'd5;         tb[4] = 32'd7;
        te[4] = 32'h0;
        tc[5] = 4'b0010; ta[5] = 32'h0000_1234; tb[5] = 32'h0000_0020;
        te[5] = 32'h0000_1234;
        tc[6] = 4'b0101; ta[6] = 32'h8000_0008; tb[6] = 32'h0000_0000;
        te[6] = 32'h8000_0008;
        for (int i = 0; i < 7; i++) begin
            issue(tc[i], ta[i], tb[i]);
            checks++;
            if (done !== 1'b1 || busy !== 1'b0 || res !== te[i] ||
                zero !== (te[i] == 32'h0)) begin
                errors++;
                $display("FAIL logic[%0d]: done=%b busy=%b res=%h zero=%b want res=%h",
                         i, done, busy, res, zero, te[i]);
            end
            step();
        end
    endtask

    task automatic test_shift(input logic [3:0] c, input logic [31:0] exp);
        int busy_cnt;
        int early;
        busy_cnt = 0;
        early    = 0;
        issue(c, 32'h8000_0000, 32'd4);
        ctrl = 4'b0000;
        opa  = 32'hFFFF_FFFF;
        opb  = 32'd1;
        for (int i = 0; i < 4; i++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done !== 1'b0) early++;
            step();
        end
        checks++;
        if (busy_cnt != 4 || early != 0) begin
            errors++;
            $display("FAIL shift_busy ctrl=%b: busy cycles=%0d early done=%0d want 4/0",
                     c, busy_cnt, early);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || res !== exp || zero !== 1'b0) begin
            errors++;
            $display("FAIL shift_res ctrl=%b: done=%b busy=%b res=%h want 1/0/%h",
                     c, done, busy, res, exp);
        end
        step();
    endtask

    task automatic test_ignore_start();
        int busy_cnt;
        busy_cnt = 0;
        issue(4'b0010, 32'd1, 32'd31);
        ctrl  = 4'b0000;
        opa   = 32'd5;
        opb   = 32'd7;
        start = 1'b1;
        for (int i = 0; i < 31; i++) begin
            if (busy === 1'b1 && done === 1'b0) busy_cnt++;
            step();
        end
        start = 1'b0;
        checks++;
        if (busy_cnt != 31) begin
            errors++;
            $display("FAIL ignore_busy: busy cycles=%0d want 31", busy_cnt);
        end
        checks++;
        if (done !== 1'b1 || res !== 32'h8000_0000 || zero !== 1'b0) begin
            errors++;
            $display("FAIL ignore_res: done=%b res=%h zero=%b want 1/80000000/0",
                     done, res, zero);
        end
        step();
    endtask

    task automatic test_flush();
        issue(4'b0000, 32'd100, 32'd23);
        step();
        issue(4'b0100, 32'hFFFF_0000, 32'd8);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || res !== 32'd123) begin
            errors++;
            $display("FAIL flush_abort: busy=%b done=%b res=%h want 0/0/0000007b",
                     busy, done, res);
        end
        issue(4'b0000, 32'd2, 32'd3);
        checks++;
        if (done !== 1'b1 || res !== 32'd5) begin
            errors++;
            $display("FAIL flush_next_add: done=%b res=%h want 1/00000005", done, res);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_quiet: done=%b busy=%b want 0/0", done, busy);
        end
    endtask

    task automatic test_flush_done();
        issue(4'b0000, 32'd1, 32'd1);
        flush = 1'b1;
        #1;
        checks++;
        if (done !== 1'b1 || res !== 32'd2) begin
            errors++;
            $display("FAIL flush_in_done: done=%b res=%h want 1/00000002", done, res);
        end
        step();
        flush = 1'b0;
        checks++;
        if (done !== 1'b0 || res !== 32'd2) begin
            errors++;
            $display("FAIL flush_after_done: done=%b res=%h want 0/00000002",
                     done, res);
        end
        flush = 1'b1;
        issue(4'b0000, 32'd4, 32'd4);
        flush = 1'b0;
        checks++;
        if (done !== 1'b0 || res !== 32'd2 || zero !== 1'b0) begin
            errors++;
            $display("FAIL flush_priority: done=%b res=%h zero=%b want 0/00000002/0",
                     done, res, zero);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  bc[4];
        logic [31:0] ba[4];
        logic [31:0] bb[4];
        logic [31:0] be[4];
        bc[0] = 4'b0000; ba[0] = 32'd1;  bb[0] = 32'd2; be[0] = 32'd3;
        bc[1] = 4'b0001; ba[1] = 32'd10; bb[1] = 32'd4; be[1] = 32'd6;
        bc[2] = 4'b0111; ba[2] = 32'hF;  bb[2] = 32'd3; be[2] = 32'd3;
        bc[3] = 4'b0011; ba[3] = 32'd5;  bb[3] = 32'd5; be[3] = 32'd0;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ctrl = bc[i];
            opa  = ba[i];
            opb  = bb[i];
            step();
            checks++;
            if (done !== 1'b1 || res !== be[i] || zero !== (be[i] == 32'h0)) begin
                errors++;
                $display("FAIL b2b[%0d]: done=%b res=%h zero=%b want 1/%h",
                         i, done, res, zero, be[i]);
            end
        end
        start = 1'b0;
        step();
    endtask

    task automatic test_reset_shift();
        int done_cnt;
        done_cnt = 0;
        issue(4'b0010, 32'd3, 32'd10);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (res !== 32'h0 || zero !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_shift: res=%h zero=%b done=%b busy=%b want 0/1/0/0",
                     res, zero, done, busy);
        end
        for (int i = 0; i < 12; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) done_cnt++;
            step();
        end
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL reset_quiet: active cycles=%0d want 0", done_cnt);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        ctrl  = 4'b0000;
        opa   = 32'h0;
        opb   = 32'h0;
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_shift(4'b0101, 32'hF800_0000);
        test_shift(4'b0100, 32'h0800_0000);
        test_ignore_start();
        test_flush();
        test_flush_done();
        test_back_to_back();
        test_reset_shift();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width in bits.
REQ-002 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start_i  input  1  request to execute one operation.
REQ-005 SHALL have port flush_i  input  1  abort the in-flight operation (pipeline flush / mispredict).
REQ-006 SHALL have port ALUCtrl_i  input  4  operation code from ALU_control.
REQ-007 SHALL have port OperandA_i  input  XLEN  first operand.
REQ-008 SHALL have port OperandB_i  input  XLEN  second operand; bits [4:0] are the shift amount.
REQ-009 SHALL have port busy_o  output  1  high while a shift is iterating.
REQ-010 SHALL have port done_o  output  1  one-cycle pulse marking a valid new Result_o.
REQ-011 SHALL have port Result_o  output  XLEN  registered result, held until the next completion.
REQ-012 SHALL have port Zero_o  output  1  registered flag, high when Result_o equals zero.

Function
REQ-013 SHALL decode ALUCtrl_i: 0000 add, 0001 sub, 0010 sll, 0011 xor, 0100 srl, 0101 sra, 0110 or, 0111 and, 1000 pass OperandB_i, 1001-1111 give result 0.
REQ-014 SHALL perform add/sub modulo 2^XLEN; no carry, overflow or exception output.
REQ-015 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-016 SHALL accept start_i only in IDLE or DONE; start_i in SHIFT is ignored, not queued.
REQ-017 For an accepted non-shift op, or a shift with shamt 0: write Result_o/Zero_o and go to DONE; done_o is high in the next cycle (latency 1).
REQ-018 For an accepted shift with shamt k (1..31): latch OperandA_i, op, and k into internal registers, then go to SHIFT.
REQ-019 In SHIFT: shift the work register by one bit per cycle (sll zero-fill, srl zero-fill, sra sign-fill) and decrement the counter; after the k-th shift, write Result_o/Zero_o and go to DONE.
REQ-020 Total shift latency SHALL be k+1 cycles from the accept edge to done_o; busy_o is high for exactly k cycles.
REQ-021 Inputs SHALL be sampled only at the accept edge; later input changes do not affect an in-flight shift.
REQ-022 done_o SHALL equal (state == DONE); DONE lasts one cycle, then returns to IDLE unless a new start_i is accepted.
REQ-023 Back-to-back single-cycle ops (start_i held high, state DONE) SHALL produce a done_o pulse every cycle.
REQ-024 flush_i SHALL have priority over start_i: the FSM goes to IDLE, no done_o is produced for the aborted op, and Result_o/Zero_o keep their previous values.
REQ-025 flush_i asserted while in DONE SHALL NOT retract the done_o already asserted in that cycle.
REQ-026 Zero_o SHALL update only together with Result_o.

Reset
REQ-027 When rst_i is high at a clock edge: state IDLE, Result_o 0, Zero_o 1, done_o 0, busy_o 0, counter 0.
REQ-028 Reset SHALL have priority over flush_i and start_i, and SHALL abort a shift in progress without producing done_o.

Verification
REQ-029 add: start with A=5, B=7, ctrl 0000 at edge N -> done_o high in cycle N+1, Result_o=12, Zero_o=0.
REQ-030 sub: A=3, B=5, ctrl 0001 -> Result_o=0xFFFFFFFE at N+1; then A=9, B=9 -> Result_o=0, Zero_o=1.
REQ-031 sra: A=0x80000000, B=4, ctrl 0101 -> busy_o high for 4 cycles, done_o at N+5, Result_o=0xF8000000; repeat with srl -> 0x08000000.
REQ-032 start_i with a new add during the SHIFT cycles of sll A=1, B=31 -> the add is ignored; done_o at N+32 with Result_o=0x80000000.
REQ-033 flush_i in cycle N+2 of an srl with shamt 8 -> no done_o, Result_o unchanged, busy_o low from N+3; an add started at N+3 completes at N+4.
REQ-034 rst_i high during an sll with shamt 10 -> next cycle all outputs at reset values; no done_o for 12 cycles without start_i.
